// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use stall FSM, redirect flushes, execute-stage forwarding.
// Optional saturating hazard event counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic [4:0]       rs1_e,
  input  logic [4:0]       rs2_e,
  input  logic [4:0]       rd_e,
  input  logic [4:0]       rd_m,
  input  logic [4:0]       rd_w,
  input  logic [1:0]       result_src_e,
  input  logic             reg_write_m,
  input  logic             reg_write_w,
  input  logic             pc_src_e,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_d,
  output logic             flush_e,
  output logic [1:0]       forward_a_e,
  output logic [1:0]       forward_b_e,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [0:0] {StRun, StLuStall} state_e;

  state_e state_q, state_d;
  logic   lu;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rdm,
                                         input logic wm, input logic [4:0] rdw,
                                         input logic ww);
    if (rs != 5'd0 && rs == rdm && wm) begin
      return 2'b10;
    end else if (rs != 5'd0 && rs == rdw && ww) begin
      return 2'b01;
    end
    return 2'b00;
  endfunction

  assign forward_a_e = fwd_sel(rs1_e, rd_m, reg_write_m, rd_w, reg_write_w);
  assign forward_b_e = fwd_sel(rs2_e, rd_m, reg_write_m, rd_w, reg_write_w);

  assign lu = (result_src_e == 2'b01) && (rd_e != 5'd0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // A redirect squashes the load-use victim anyway, so it always beats the stall.
  always_comb begin
    state_d = StRun;
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (pc_src_e) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (state_q == StRun && lu) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
      state_d = StLuStall;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_d && stall_cnt_q != '1) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (pc_src_e && flush_cnt_q != '1) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
